gshare_tournament_predictor: RTL

//  Parametrised branch-prediction unit for the pipelined RV32I core: BTB + direction predictor selectable as

---
 rtl/gshare_tournament_predictor.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/gshare_tournament_predictor.sv
// gshare_tournament_predictor: direct-mapped BTB plus a bimodal, gshare or
// tournament direction predictor with speculative GHR and restore on flush.
module gshare_tournament_predictor #(
  parameter int PC_W    = 32,
  parameter int BHT_IDX = 10,
  parameter int HIST_W  = 10,
  parameter int BTB_IDX = 6,
  parameter int MODE    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   lu_pc,
  input  logic              lu_advance,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  output logic              pred_hit,
  output logic [HIST_W-1:0] pred_ghr,
  input  logic              up_valid,
  input  logic [PC_W-1:0]   up_pc,
  input  logic              up_is_branch,
  input  logic              up_is_jump,
  input  logic              up_taken,
  input  logic [PC_W-1:0]   up_target,
  input  logic [HIST_W-1:0] up_ghr,
  input  logic              up_mispredict,
  input  logic              stat_clr,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_updates,
  output logic [31:0]       stat_mispred
);

  localparam int NB    = 1 << BHT_IDX;
  localparam int NT    = 1 << BTB_IDX;
  localparam int TAG_W = PC_W - BTB_IDX - 2;

  logic [1:0]        bim_q [NB];
  logic [1:0]        gsh_q [NB];
  logic [1:0]        cho_q [NB];
  logic              btb_v_q   [NT];
  logic [TAG_W-1:0]  btb_tag_q [NT];
  logic [PC_W-1:0]   btb_tgt_q [NT];
  logic              btb_j_q   [NT];
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [31:0]       st_lu_q, st_up_q, st_mp_q;

  logic [BHT_IDX-1:0] lu_bi, lu_gs, lu_h;
  logic [BHT_IDX-1:0] up_bi, up_gs, up_h;
  logic [BTB_IDX-1:0] lu_bt, up_bt;
  logic [HIST_W-1:0]  spec_ghr, rest_ghr;
  logic               bi_dir, gs_dir, dir;
  logic               bi_ok, gs_ok, rest_bit, btb_wr;
  logic [1:0]         bim_d, gsh_d, cho_d;
  logic               unused_bits;

  function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [31:0] bump(input logic [31:0] v, input logic inc);
    return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  assign lu_bi = lu_pc[BHT_IDX+1:2];
  assign up_bi = up_pc[BHT_IDX+1:2];
  assign lu_bt = lu_pc[BTB_IDX+1:2];
  assign up_bt = up_pc[BTB_IDX+1:2];

  generate
    if (HIST_W >= BHT_IDX) begin : g_hfold
      assign lu_h = ghr_q[BHT_IDX-1:0];
      assign up_h = up_ghr[BHT_IDX-1:0];
    end else begin : g_hext
      assign lu_h = {{(BHT_IDX-HIST_W){1'b0}}, ghr_q};
      assign up_h = {{(BHT_IDX-HIST_W){1'b0}}, up_ghr};
    end
  endgenerate

  assign lu_gs = lu_bi ^ lu_h;
  assign up_gs = up_bi ^ up_h;

  assign bi_dir = bim_q[lu_bi][1];
  assign gs_dir = gsh_q[lu_gs][1];

  // Select the direction source for the configured predictor flavour
  always_comb begin
    dir = bi_dir;
    if (MODE == 1) dir = gs_dir;
    else if (MODE == 2) dir = cho_q[lu_bi][1] ? gs_dir : bi_dir;
  end

  assign pred_hit = btb_v_q[lu_bt] &&
                    (btb_tag_q[lu_bt] == lu_pc[PC_W-1:BTB_IDX+2]);
  assign pred_taken  = pred_hit & (btb_j_q[lu_bt] | dir);
  assign pred_target = btb_tgt_q[lu_bt];
  assign pred_ghr    = ghr_q;

  assign rest_bit = up_is_jump | up_taken;

  generate
    if (HIST_W == 1) begin : g_h1
      assign spec_ghr = pred_taken;
      assign rest_ghr = rest_bit;
    end else begin : g_hn
      assign spec_ghr = {ghr_q[HIST_W-2:0], pred_taken};
      assign rest_ghr = {up_ghr[HIST_W-2:0], rest_bit};
    end
  endgenerate

  // Flush restore beats the speculative shift of the same cycle
  always_comb begin
    ghr_d = ghr_q;
    if (up_valid && up_mispredict) ghr_d = rest_ghr;
    else if (lu_advance && pred_hit) ghr_d = spec_ghr;
  end

  // Global history register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end

  assign bi_ok = (bim_q[up_bi][1] == up_taken);
  assign gs_ok = (gsh_q[up_gs][1] == up_taken);
  assign bim_d = sat2(bim_q[up_bi], up_taken);
  assign gsh_d = sat2(gsh_q[up_gs], up_taken);
  assign cho_d = sat2(cho_q[up_bi], gs_ok);

  // Direction counters and chooser, trained on resolved branches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        bim_q[i] <= 2'b01;
        gsh_q[i] <= 2'b01;
        cho_q[i] <= 2'b10;
      end
    end else if (up_valid && up_is_branch) begin
      bim_q[up_bi] <= bim_d;
      gsh_q[up_gs] <= gsh_d;
      if (MODE == 2 && (gs_ok != bi_ok)) cho_q[up_bi] <= cho_d;
    end
  end

  assign btb_wr = up_valid & (up_is_jump | (up_is_branch & up_taken));

  // BTB valid bits; only taken control flow allocates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NT; i++) btb_v_q[i] <= 1'b0;
    end else if (btb_wr) begin
      btb_v_q[up_bt] <= 1'b1;
    end
  end

  // BTB payload, qualified by the valid bits so no reset needed
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      btb_tag_q[up_bt] <= up_pc[PC_W-1:BTB_IDX+2];
      btb_tgt_q[up_bt] <= up_target;
      btb_j_q[up_bt]   <= up_is_jump;
    end
  end

  // Saturating statistics counters, clear dominates increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_lu_q <= '0;
      st_up_q <= '0;
      st_mp_q <= '0;
    end else if (stat_clr) begin
      st_lu_q <= '0;
      st_up_q <= '0;
      st_mp_q <= '0;
    end else begin
      st_lu_q <= bump(st_lu_q, lu_advance);
      st_up_q <= bump(st_up_q, up_valid & up_is_branch);
      st_mp_q <= bump(st_mp_q, up_valid & up_mispredict);
    end
  end

  assign stat_lookups = st_lu_q;
  assign stat_updates = st_up_q;
  assign stat_mispred = st_mp_q;

  assign unused_bits = ^{lu_pc[1:0], up_pc[1:0], up_ghr, ghr_q};

endmodule
